// File: rtl/mioc_dram_pkg.sv
// Shared types and default timing for the MIOC DRAM arbiter.
package mioc_dram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRow,
    StCol,
    StCas,
    StRrow,
    StPre
  } state_e;

  typedef enum logic [1:0] {
    GntNone = 2'b00,
    GntCpu  = 2'b01,
    GntDma  = 2'b10,
    GntRfsh = 2'b11
  } grant_e;

  localparam int unsigned RfshPeriodDef   = 56;
  localparam int unsigned RfshCntWDef     = 8;
  localparam int unsigned CasCyclesDef    = 2;
  localparam int unsigned PrechgCyclesDef = 1;
  localparam int unsigned RfshOwedMaxDef  = 3;
  // Wide enough for the longest phase: RROW lasts 2+CAS_CYCLES <= 5 cycles.
  localparam int unsigned PhaseW          = 3;

endpackage

// File: rtl/mioc_rfsh_timer.sv
// Refresh period counter with a saturating count of owed refresh cycles.
module mioc_rfsh_timer #(
  parameter int unsigned RFSH_PERIOD   = 56,
  parameter int unsigned RFSH_CNT_W    = 8,
  parameter int unsigned RFSH_OWED_MAX = 3,
  parameter int unsigned OWED_W        = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dec_i,
  output logic [OWED_W-1:0] owed_o
);

  logic [RFSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [OWED_W-1:0]     owed_q, owed_d;
  logic                  tick;

  always_comb begin
    tick   = (cnt_q == RFSH_CNT_W'(RFSH_PERIOD - 1));
    cnt_d  = tick ? '0 : cnt_q + RFSH_CNT_W'(1);
    owed_d = owed_q;
    // A tick and a grant in the same cycle cancel out.
    if (tick && !dec_i) begin
      if (owed_q != OWED_W'(RFSH_OWED_MAX)) owed_d = owed_q + OWED_W'(1);
    end else if (!tick && dec_i && (owed_q != '0)) begin
      owed_d = owed_q - OWED_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      owed_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      owed_q <= owed_d;
    end
  end

  assign owed_o = owed_q;

endmodule

// File: rtl/mioc_dram_arbiter.sv
// DRAM strobe sequencer and CPU/DMA/refresh arbiter for the MIOC.
// Optional MIOC_DMA_FAIR_EN: CPU and DMA alternate on a tie instead of DMA always winning.
module mioc_dram_arbiter
  import mioc_dram_pkg::*;
#(
  parameter int unsigned RFSH_PERIOD   = RfshPeriodDef,
  parameter int unsigned RFSH_CNT_W    = RfshCntWDef,
  parameter int unsigned CAS_CYCLES    = CasCyclesDef,
  parameter int unsigned PRECHG_CYCLES = PrechgCyclesDef,
  parameter int unsigned RFSH_OWED_MAX = RfshOwedMaxDef
) (
  input  logic       B_PHI,
  input  logic       RST,
  input  logic       CPU_REQ,
  input  logic       CPU_BANK,
  input  logic       DMA_REQ,
  input  logic       DMA_BANK,
  output logic       CPU_ACK,
  output logic       DMA_ACK,
  output logic       WAIT_N,
  output logic [1:0] GRANT,
  output logic       RAS_N,
  output logic       MUX,
  output logic       CAS1_N,
  output logic       CAS2_N
);

  localparam int unsigned OwedW = $clog2(RFSH_OWED_MAX + 1);

  logic [OwedW-1:0]  owed;
  logic              rfsh_dec;
  state_e            state_q, state_d;
  grant_e            owner_q, owner_d;
  logic              bank_q, bank_d;
  logic [PhaseW-1:0] cnt_q, cnt_d;
  logic              pick_dma, cas_last;
  logic              ras_n_q, ras_n_d, mux_q, mux_d;
  logic              cas1_n_q, cas1_n_d, cas2_n_q, cas2_n_d;
  logic              cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
  logic              wait_n_q, wait_n_d;

  mioc_rfsh_timer #(
    .RFSH_PERIOD  (RFSH_PERIOD),
    .RFSH_CNT_W   (RFSH_CNT_W),
    .RFSH_OWED_MAX(RFSH_OWED_MAX),
    .OWED_W       (OwedW)
  ) u_rfsh_timer (
    .clk_i (B_PHI),
    .rst_i (RST),
    .dec_i (rfsh_dec),
    .owed_o(owed)
  );

`ifdef MIOC_DMA_FAIR_EN
  logic last_dma_q, last_dma_d;

  assign pick_dma = DMA_REQ && (!CPU_REQ || !last_dma_q);

  always_comb begin
    last_dma_d = last_dma_q;
    if (state_q == StIdle && owner_d == GntDma) last_dma_d = 1'b1;
    if (state_q == StIdle && owner_d == GntCpu) last_dma_d = 1'b0;
  end

  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) last_dma_q <= 1'b0;
    else     last_dma_q <= last_dma_d;
  end
`else
  assign pick_dma = DMA_REQ;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    bank_d   = bank_q;
    cnt_d    = cnt_q;
    rfsh_dec = 1'b0;
    unique case (state_q)
      StIdle: begin
        owner_d = GntNone;
        if (owed > OwedW'(1) || (!DMA_REQ && !CPU_REQ && owed != '0)) begin
          state_d  = StRrow;
          owner_d  = GntRfsh;
          cnt_d    = '0;
          rfsh_dec = 1'b1;
        end else if (pick_dma) begin
          state_d = StRow;
          owner_d = GntDma;
          bank_d  = DMA_BANK;
        end else if (CPU_REQ) begin
          state_d = StRow;
          owner_d = GntCpu;
          bank_d  = CPU_BANK;
        end
      end
      StRow: state_d = StCol;
      StCol: begin
        state_d = StCas;
        cnt_d   = '0;
      end
      StCas: begin
        if (cnt_q == PhaseW'(CAS_CYCLES - 1)) begin
          state_d = StPre;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PhaseW'(1);
        end
      end
      StRrow: begin
        if (cnt_q == PhaseW'(CAS_CYCLES + 1)) begin
          state_d = StPre;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PhaseW'(1);
        end
      end
      StPre: begin
        if (cnt_q == PhaseW'(PRECHG_CYCLES - 1)) begin
          state_d = StIdle;
          owner_d = GntNone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PhaseW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = GntNone;
      end
    endcase

    // Strobes are decoded from the next state so every output leaves a flop.
    ras_n_d   = !(state_d inside {StRow, StCol, StCas, StRrow});
    mux_d     = state_d inside {StCol, StCas};
    cas1_n_d  = !(state_d == StCas && !bank_d);
    cas2_n_d  = !(state_d == StCas && bank_d);
    cas_last  = (state_d == StCas) && (cnt_d == PhaseW'(CAS_CYCLES - 1));
    cpu_ack_d = cas_last && (owner_d == GntCpu);
    dma_ack_d = cas_last && (owner_d == GntDma);
    wait_n_d  = !(CPU_REQ && owner_d != GntCpu);
  end

  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      owner_q   <= GntNone;
      bank_q    <= 1'b0;
      cnt_q     <= '0;
      ras_n_q   <= 1'b1;
      mux_q     <= 1'b0;
      cas1_n_q  <= 1'b1;
      cas2_n_q  <= 1'b1;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      wait_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      bank_q    <= bank_d;
      cnt_q     <= cnt_d;
      ras_n_q   <= ras_n_d;
      mux_q     <= mux_d;
      cas1_n_q  <= cas1_n_d;
      cas2_n_q  <= cas2_n_d;
      cpu_ack_q <= cpu_ack_d;
      dma_ack_q <= dma_ack_d;
      wait_n_q  <= wait_n_d;
    end
  end

  assign GRANT   = owner_q;
  assign RAS_N   = ras_n_q;
  assign MUX     = mux_q;
  assign CAS1_N  = cas1_n_q;
  assign CAS2_N  = cas2_n_q;
  assign CPU_ACK = cpu_ack_q;
  assign DMA_ACK = dma_ack_q;
  assign WAIT_N  = wait_n_q;

endmodule

// File: tb/tb_mioc_dram_arbiter.sv
// Bench for mioc_dram_arbiter: timeline model compared every cycle plus pinned literal checks.
module tb_mioc_dram_arbiter;

  localparam int Period  = 56;
  localparam int Cas     = 2;
  localparam int Pre     = 1;
  localparam int OwedMax = 3;
  localparam int Len     = 2 + Cas + Pre;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_bank = 1'b0, dma_req = 1'b0, dma_bank = 1'b0;
  logic       cpu_ack, dma_ack, wait_n, ras_n, mux, cas1_n, cas2_n;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;
  bit cpu_hold = 0;
  bit dma_hold = 0;

  always #5 clk = ~clk;

  mioc_dram_arbiter dut (
    .B_PHI   (clk),
    .RST     (rst),
    .CPU_REQ (cpu_req),
    .CPU_BANK(cpu_bank),
    .DMA_REQ (dma_req),
    .DMA_BANK(dma_bank),
    .CPU_ACK (cpu_ack),
    .DMA_ACK (dma_ack),
    .WAIT_N  (wait_n),
    .GRANT   (grant),
    .RAS_N   (ras_n),
    .MUX     (mux),
    .CAS1_N  (cas1_n),
    .CAS2_N  (cas2_n)
  );

  // Model: owner 0 none, 1 cpu, 2 dma, 3 refresh; off = cycles since grant (1..Len).
  typedef struct {
    int cyc;
    int pc;
    int owed;
    int owner;
    int off;
    bit bank;
    bit last_dma;
    bit wait_n;
  } m_t;

  m_t m;

  function automatic m_t m_reset();
    m_t r;
    r.cyc = 0; r.pc = 0; r.owed = 0; r.owner = 0; r.off = 0;
    r.bank = 0; r.last_dma = 0; r.wait_n = 1;
    return r;
  endfunction

  function automatic m_t m_step(m_t s, logic creq, logic cbank, logic dreq, logic dbank);
    m_t n;
    int g;
    bit tick;
    n = s;
    g = 0;
    tick = (s.pc == Period - 1);
    n.pc = tick ? 0 : s.pc + 1;
    if (s.owner == 0) begin
      if (s.owed >= 2) g = 3;
      else if (dreq && creq) begin
`ifdef MIOC_DMA_FAIR_EN
        g = s.last_dma ? 1 : 2;
`else
        g = 2;
`endif
      end
      else if (dreq) g = 2;
      else if (creq) g = 1;
      else if (s.owed >= 1) g = 3;
      if (g != 0) begin
        n.owner = g;
        n.off   = 1;
        n.bank  = (g == 2) ? dbank : cbank;
        if (g == 1) n.last_dma = 0;
        if (g == 2) n.last_dma = 1;
      end
    end else begin
      n.off = s.off + 1;
      if (n.off > Len) begin
        n.owner = 0;
        n.off   = 0;
      end
    end
    if (tick && g != 3) n.owed = (s.owed < OwedMax) ? s.owed + 1 : OwedMax;
    else if (!tick && g == 3) n.owed = s.owed - 1;
    n.wait_n = !(creq && n.owner != 1);
    n.cyc = s.cyc + 1;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= m_reset();
    else     m <= m_step(m, cpu_req, cpu_bank, dma_req, dma_bank);
  end

  // Expected outputs packed as {ras_n, mux, cas1_n, cas2_n, cpu_ack, dma_ack, wait_n, grant}.
  function automatic logic [8:0] m_exp(m_t s);
    bit acc, in_ras, in_col, in_cas;
    acc    = (s.owner == 1) || (s.owner == 2);
    in_ras = (s.owner != 0) && (s.off <= 2 + Cas);
    in_col = acc && (s.off >= 2) && (s.off <= 2 + Cas);
    in_cas = acc && (s.off >= 3) && (s.off <= 2 + Cas);
    return {!in_ras, in_col, !(in_cas && !s.bank), !(in_cas && s.bank),
            acc && s.owner == 1 && s.off == 2 + Cas,
            acc && s.owner == 2 && s.off == 2 + Cas,
            s.wait_n, 2'(s.owner)};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {ras_n, mux, cas1_n, cas2_n, cpu_ack, dma_ack, wait_n, grant};
  endfunction

  task automatic compare_cycle();
    logic [8:0] got, exp;
    got = dut_vec();
    exp = m_exp(m);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_model cyc=%0d got {ras_n,mux,cas1_n,cas2_n,cack,dack,wait_n,grant}=%b exp=%b",
               m.cyc, got, exp);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, m.cyc, got, exp);
    end
  endtask

  // Advance to cycle n, comparing every cycle; requesters drop REQ on the model's ACK.
  task automatic goto(input int n);
    while (m.cyc < n) begin
      @(negedge clk);
      compare_cycle();
      if (m_exp(m)[4] && !cpu_hold) cpu_req = 1'b0;
      if (m_exp(m)[3] && !dma_hold) dma_req = 1'b0;
    end
  endtask

  initial begin
    int n_rf, n_dma, n_cpu;
    logic [1:0] prev;

    // Reset values
    #12;
    chk("reset_vec", int'(dut_vec()), int'(9'b1_0_1_1_0_0_1_00));
    @(negedge clk);
    rst = 1'b0;

    // Refresh only: first RAS_N low at cycle 57 for 4 cycles
    goto(56); chk("rfsh_ras_before", ras_n, 1);
    goto(57); chk("rfsh_ras_low", ras_n, 0); chk("rfsh_grant", grant, 3);
    chk("rfsh_cas1", cas1_n, 1); chk("rfsh_cas2", cas2_n, 1);
    goto(60); chk("rfsh_ras_last", ras_n, 0);
    goto(61); chk("rfsh_pre_ras", ras_n, 1); chk("rfsh_pre_grant", grant, 3);
    goto(62); chk("rfsh_idle_grant", grant, 0);

    // Idle CPU access, bank 0
    cpu_req = 1'b1; cpu_bank = 1'b0;
    goto(63); chk("cpu_row_ras", ras_n, 0); chk("cpu_row_mux", mux, 0); chk("cpu_wait", wait_n, 1);
    goto(64); chk("cpu_col_mux", mux, 1); chk("cpu_col_cas1", cas1_n, 1);
    goto(65); chk("cpu_cas1_a", cas1_n, 0);
    goto(66); chk("cpu_cas1_b", cas1_n, 0); chk("cpu_ack", cpu_ack, 1); chk("cpu_cas2", cas2_n, 1);
    goto(67); chk("cpu_pre_ras", ras_n, 1); chk("cpu_pre_cas1", cas1_n, 1);
    chk("cpu_pre_mux", mux, 0); chk("cpu_ack_gone", cpu_ack, 0);

    // CPU and DMA together: DMA first on bank 1, CPU 6 cycles later
    goto(80);
    cpu_req = 1'b1; cpu_bank = 1'b0; dma_req = 1'b1; dma_bank = 1'b1;
    goto(81); chk("tie_grant_dma", grant, 2); chk("tie_wait_low", wait_n, 0);
    goto(82); dma_bank = 1'b0;
    goto(83); chk("dma_cas2", cas2_n, 0); chk("dma_cas1", cas1_n, 1);
    goto(84); chk("dma_ack", dma_ack, 1); chk("dma_no_cpu_ack", cpu_ack, 0);
    goto(86); chk("tie_wait_idle", wait_n, 0); chk("tie_idle_grant", grant, 0);
    goto(87); chk("tie_grant_cpu", grant, 1); chk("tie_wait_high", wait_n, 1);
    goto(90); chk("tie_cpu_ack", cpu_ack, 1); chk("tie_cpu_cas1", cas1_n, 0);

    // Continuous DMA across two refresh periods: one refresh squeezed in
    goto(100);
    dma_hold = 1; dma_req = 1'b1; dma_bank = 1'b1;
    n_rf = 0; prev = 2'b00;
    for (int c = 100; c < 200; c++) begin
      goto(c);
      if (grant == 2'b11 && prev != 2'b11) n_rf++;
      prev = grant;
      if (c == 173) chk("dma_stream_rfsh_at_173", grant, 3);
      if (c == 199) begin
        dma_hold = 0; dma_req = 1'b0;
      end
    end
    chk("dma_stream_rfsh_count", n_rf, 1);
    goto(200); chk("dma_drop_early_ack", dma_ack, 1);
    goto(203); chk("owed_left_rfsh", grant, 3);

    // CPU and DMA held continuously
    goto(210);
    cpu_hold = 1; dma_hold = 1; cpu_req = 1'b1; dma_req = 1'b1;
    cpu_bank = 1'b0; dma_bank = 1'b1;
    n_dma = 0; n_cpu = 0; prev = 2'b00;
    for (int c = 210; c < 260; c++) begin
      goto(c);
      if (grant == 2'b10 && prev != 2'b10) n_dma++;
      if (grant == 2'b01 && prev != 2'b01) n_cpu++;
      prev = grant;
    end
`ifdef MIOC_DMA_FAIR_EN
    chk("fair_dma_grants", n_dma, 4);
    chk("fair_cpu_grants", n_cpu, 5);
`else
    chk("fixed_dma_grants", n_dma, 9);
    chk("fixed_cpu_grants", n_cpu, 0);
`endif
    cpu_hold = 0; dma_hold = 0; cpu_req = 1'b0; dma_req = 1'b0;

    // CPU drops REQ before ACK, bank 1
    goto(280);
    cpu_req = 1'b1; cpu_bank = 1'b1;
    goto(282); cpu_req = 1'b0;
    goto(283); chk("cpu_drop_cas2", cas2_n, 0);
    goto(284); chk("cpu_drop_ack", cpu_ack, 1); chk("cpu_drop_cas1", cas1_n, 1);

    // Reset during CAS
    goto(292);
    cpu_req = 1'b1; cpu_bank = 1'b0;
    goto(295); chk("pre_rst_cas1", cas1_n, 0);
    rst = 1'b1; cpu_req = 1'b0;
    #1;
    chk("rst_ras", ras_n, 1); chk("rst_cas1", cas1_n, 1); chk("rst_cas2", cas2_n, 1);
    chk("rst_ack", cpu_ack, 0); chk("rst_grant", grant, 0);
    @(negedge clk);
    rst = 1'b0;
    goto(1); chk("post_rst_grant", grant, 0); chk("post_rst_ras", ras_n, 1);
    goto(5); cpu_req = 1'b1; cpu_bank = 1'b1;
    goto(9); chk("post_rst_ack", cpu_ack, 1); chk("post_rst_cas2", cas2_n, 0);
    goto(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
